// File: rtl/wb_host_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the ethmac Wishbone slave.
// The arbiter takes the master view; the environment (requesters + slave) takes the slave view.
interface wb_host_arbiter_if #(
  parameter int AW = 10
);
  logic          m0_req_i;
  logic          m1_req_i;
  logic          m0_we_i;
  logic          m1_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [AW-1:0] m1_adr_i;
  logic [31:0]   m0_dat_i;
  logic [31:0]   m1_dat_i;
  logic [3:0]    m0_sel_i;
  logic [3:0]    m1_sel_i;
  logic          m0_done_o;
  logic          m1_done_o;
  logic          m0_err_o;
  logic          m1_err_o;
  logic [31:0]   m0_dat_o;
  logic [31:0]   m1_dat_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [1:0]    grant_o;

  modport master (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i, wb_dat_i, wb_ack_i, wb_err_i,
    output m0_done_o, m1_done_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, grant_o
  );

  modport slave (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  m0_done_o, m1_done_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, grant_o
  );
endinterface

// File: rtl/wb_host_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic-cycle master port between two requesters,
// with per-requester done/err/read-data returns and an abort for slaves that never respond.
module wb_host_arbiter #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  wb_host_arbiter_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_r, state_s;
  logic          last_m1_r, last_m1_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [AW-1:0] adr_r, adr_s;
  logic [31:0]   wdat_r, wdat_s;
  logic [3:0]    sel_r, sel_s;
  logic          we_r, we_s;
  logic          cyc_r, cyc_s;
  logic [1:0]    grant_r, grant_s;
  logic [1:0]    done_r, done_s;
  logic [1:0]    err_r, err_s;
  logic [31:0]   rdat0_r, rdat0_s;
  logic [31:0]   rdat1_r, rdat1_s;
  logic          pick_m1_s;
  logic          finish_s;
  logic          capture_s;

  // Next-state and next-output logic for the IDLE/BUS/GAP transfer sequencer
  always_comb begin
    state_s   = state_r;
    last_m1_s = last_m1_r;
    cnt_s     = cnt_r;
    adr_s     = adr_r;
    wdat_s    = wdat_r;
    sel_s     = sel_r;
    we_s      = we_r;
    cyc_s     = cyc_r;
    grant_s   = grant_r;
    done_s    = 2'b00;
    err_s     = 2'b00;
    rdat0_s   = rdat0_r;
    rdat1_s   = rdat1_r;
    pick_m1_s = 1'b0;
    finish_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          // m1 wins when alone, or when both ask and m0 was served last
          pick_m1_s = bus.m1_req_i && (!bus.m0_req_i || !last_m1_r);
          if (pick_m1_s) begin
            adr_s   = bus.m1_adr_i;
            wdat_s  = bus.m1_dat_i;
            sel_s   = bus.m1_sel_i;
            we_s    = bus.m1_we_i;
            grant_s = 2'b10;
          end else begin
            adr_s   = bus.m0_adr_i;
            wdat_s  = bus.m0_dat_i;
            sel_s   = bus.m0_sel_i;
            we_s    = bus.m0_we_i;
            grant_s = 2'b01;
          end
          last_m1_s = pick_m1_s;
          cnt_s     = 8'd0;
          cyc_s     = 1'b1;
          state_s   = ST_BUS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        finish_s = bus.wb_err_i || bus.wb_ack_i || (cnt_r == TO_LAST);
        if (finish_s) begin
          // err has priority over ack; a silent slave ends here as a timeout error
          capture_s = bus.wb_ack_i && !bus.wb_err_i && !we_r;
          rdat0_s   = (capture_s && grant_r[0]) ? bus.wb_dat_i : rdat0_r;
          rdat1_s   = (capture_s && grant_r[1]) ? bus.wb_dat_i : rdat1_r;
          done_s    = grant_r;
          err_s     = (bus.wb_err_i || !bus.wb_ack_i) ? grant_r : 2'b00;
          cyc_s     = 1'b0;
          grant_s   = 2'b00;
          state_s   = ST_GAP;
        end else if (cnt_r != 8'hFF) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        cyc_s   = 1'b0;
        grant_s = 2'b00;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves m0 with round-robin priority
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r   <= ST_IDLE;
      last_m1_r <= 1'b1;
      cnt_r     <= 8'd0;
      adr_r     <= '0;
      wdat_r    <= 32'd0;
      sel_r     <= 4'd0;
      we_r      <= 1'b0;
      cyc_r     <= 1'b0;
      grant_r   <= 2'b00;
      done_r    <= 2'b00;
      err_r     <= 2'b00;
      rdat0_r   <= 32'd0;
      rdat1_r   <= 32'd0;
    end else begin
      state_r   <= state_s;
      last_m1_r <= last_m1_s;
      cnt_r     <= cnt_s;
      adr_r     <= adr_s;
      wdat_r    <= wdat_s;
      sel_r     <= sel_s;
      we_r      <= we_s;
      cyc_r     <= cyc_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      err_r     <= err_s;
      rdat0_r   <= rdat0_s;
      rdat1_r   <= rdat1_s;
    end
  end

  assign bus.wb_adr_o  = adr_r;
  assign bus.wb_dat_o  = wdat_r;
  assign bus.wb_sel_o  = sel_r;
  assign bus.wb_we_o   = we_r;
  assign bus.wb_cyc_o  = cyc_r;
  assign bus.wb_stb_o  = cyc_r;
  assign bus.grant_o   = grant_r;
  assign bus.m0_done_o = done_r[0];
  assign bus.m1_done_o = done_r[1];
  assign bus.m0_err_o  = err_r[0];
  assign bus.m1_err_o  = err_r[1];
  assign bus.m0_dat_o  = rdat0_r;
  assign bus.m1_dat_o  = rdat1_r;

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Self-checking bench for wb_host_arbiter: directed vector table, hand-written corner sequences
// and randomized rounds checked against a transaction-level model of the arbiter.
module tb_wb_host_arbiter;

  localparam int AW = 10;
  localparam int TO = 16;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_SIL  = 3;

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    int            mode;
    int            wt;
    logic [31:0]   rdata;
    bit            exp_err;
    int            exp_len;
  } req_t;

  typedef struct {
    bit   r0;
    bit   r1;
    req_t q;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_host_arbiter_if #(.AW(AW)) bus ();

  wb_host_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  req_t        cfg [2];
  logic [31:0] rd_model [2];
  int          exp_own [$];
  bit          pending [2];
  bit          active;
  int          cur;
  int          len;
  int          tick;
  int          rise_tick;
  int          raise_tick;
  int          last_done_tick;
  bit          prev_cyc;
  bit          prio_m1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tick);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [AW-1:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int mode, input int wt,
                              input logic [31:0] rdata, input bit exp_err, input int exp_len);
    req_t r;
    r.we = we; r.adr = adr; r.dat = dat; r.sel = sel; r.mode = mode; r.wt = wt;
    r.rdata = rdata; r.exp_err = exp_err; r.exp_len = exp_len;
    return r;
  endfunction

  // Reference outcome from the protocol rules: any non-plain-ack ends in error, silence lasts TO cycles
  function automatic req_t rnd_req();
    req_t r;
    r.we      = 1'($urandom_range(0, 1));
    r.adr     = AW'($urandom);
    r.dat     = $urandom;
    r.sel     = 4'($urandom);
    r.mode    = $urandom_range(0, 3);
    r.wt      = $urandom_range(0, 3);
    r.rdata   = $urandom;
    r.exp_err = (r.mode != M_ACK);
    r.exp_len = (r.mode == M_SIL) ? TO : r.wt + 1;
    return r;
  endfunction

  task automatic set_req(input int x, input bit r, input req_t q);
    if (x == 0) begin
      bus.m0_req_i = r; bus.m0_we_i = q.we; bus.m0_adr_i = q.adr;
      bus.m0_dat_i = q.dat; bus.m0_sel_i = q.sel;
    end else begin
      bus.m1_req_i = r; bus.m1_we_i = q.we; bus.m1_adr_i = q.adr;
      bus.m1_dat_i = q.dat; bus.m1_sel_i = q.sel;
    end
  endtask

  task automatic reset_model();
    for (int x = 0; x < 2; x++) begin
      rd_model[x] = 32'd0;
      pending[x]  = 1'b0;
    end
    exp_own.delete();
    active = 1'b0; cur = -1; len = 0; prev_cyc = 1'b0; prio_m1 = 1'b0;
    last_done_tick = -100; raise_tick = -100; rise_tick = 0;
  endtask

  // One clock: sample just after the edge, check, then act as the Wishbone slave for the next edge
  task automatic step();
    logic [1:0]  dn;
    logic [1:0]  er;
    logic [31:0] dq [2];
    logic [31:0] exp_rise;
    logic [1:0]  exp_gnt;
    bit          hit;
    @(posedge clk);
    #1;
    tick++;
    dn = {bus.m1_done_o, bus.m0_done_o};
    er = {bus.m1_err_o, bus.m0_err_o};
    dq[0] = bus.m0_dat_o;
    dq[1] = bus.m1_dat_o;
    for (int x = 0; x < 2; x++) begin
      if (dn[x]) begin
        chk("done_owner", 32'(x), active ? 32'(cur) : 32'hFFFF_FFFF);
        chk("done_err", 32'(er[x]), 32'(cfg[x].exp_err));
        chk("stb_len", 32'(len), 32'(cfg[x].exp_len));
        chk("done_time", 32'(tick), 32'(rise_tick + cfg[x].exp_len));
        if (!cfg[x].exp_err && !cfg[x].we) rd_model[x] = cfg[x].rdata;
        pending[x] = 1'b0;
        active = 1'b0;
        last_done_tick = tick;
        if (x == 0) bus.m0_req_i = 1'b0; else bus.m1_req_i = 1'b0;
      end else begin
        if (er[x]) chk("err_without_done", 32'(er[x]), 32'd0);
      end
      chk(x == 0 ? "m0_dat_o" : "m1_dat_o", dq[x], rd_model[x]);
    end
    if (bus.wb_cyc_o && !prev_cyc) begin
      chk("grant_expected", 32'(exp_own.size() > 0), 32'd1);
      cur = (exp_own.size() > 0) ? exp_own.pop_front() : 0;
      active = 1'b1; rise_tick = tick; len = 1;
      exp_gnt = (cur == 1) ? 2'b10 : 2'b01;
      exp_rise = (raise_tick + 1 > last_done_tick + 2) ? 32'(raise_tick + 1) : 32'(last_done_tick + 2);
      chk("grant", 32'(bus.grant_o), 32'(exp_gnt));
      chk("rise_time", 32'(tick), exp_rise);
      chk("wb_adr", 32'(bus.wb_adr_o), 32'(cfg[cur].adr));
      chk("wb_dat", bus.wb_dat_o, cfg[cur].dat);
      chk("wb_sel", 32'(bus.wb_sel_o), 32'(cfg[cur].sel));
      chk("wb_we", 32'(bus.wb_we_o), 32'(cfg[cur].we));
    end else if (bus.wb_cyc_o) begin
      len++;
    end
    chk("stb_eq_cyc", 32'(bus.wb_stb_o), 32'(bus.wb_cyc_o));
    if (!bus.wb_cyc_o) chk("grant_idle", 32'(bus.grant_o), 32'd0);
    if (bus.wb_cyc_o && active) begin
      hit = ((len - 1) == cfg[cur].wt);
      bus.wb_ack_i = hit && (cfg[cur].mode == M_ACK || cfg[cur].mode == M_BOTH);
      bus.wb_err_i = hit && (cfg[cur].mode == M_ERR || cfg[cur].mode == M_BOTH);
      bus.wb_dat_i = bus.wb_ack_i ? cfg[cur].rdata : $urandom;
    end else begin
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = $urandom;
    end
    prev_cyc = bus.wb_cyc_o;
  endtask

  // Issue requests from idle, predict the service order by round-robin, run until all are done
  task automatic run_round(input bit r0, input bit r1, input req_t q0, input req_t q1, input bit withdraw);
    int first;
    cfg[0] = q0;
    cfg[1] = q1;
    if (r0 && r1) begin
      first = prio_m1 ? 1 : 0;
      exp_own.push_back(first);
      exp_own.push_back(1 - first);
      prio_m1 = (first == 1);
    end else if (r0) begin
      exp_own.push_back(0);
      prio_m1 = 1'b1;
    end else begin
      exp_own.push_back(1);
      prio_m1 = 1'b0;
    end
    pending[0] = r0;
    pending[1] = r1;
    raise_tick = tick;
    set_req(0, r0, q0);
    set_req(1, r1, q1);
    for (int i = 0; i < 300 && (pending[0] || pending[1]); i++) begin
      step();
      if (withdraw && active && cur == 0 && len == 2) bus.m0_req_i = 1'b0;
    end
    chk("round_complete", 32'({pending[0], pending[1]}), 32'd0);
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    exp_own.delete();
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    req_t q;
    req_t q1;
    bit   r0;
    bit   r1;

    vecs[0] = '{1'b1, 1'b0, mk(1'b1, 10'h010, 32'hA5A5_0001, 4'hF, M_ACK,  2, 32'h0,         1'b0, 3)};
    vecs[1] = '{1'b0, 1'b1, mk(1'b0, 10'h100, 32'h0,         4'hF, M_ACK,  0, 32'hDEAD_BEEF, 1'b0, 1)};
    vecs[2] = '{1'b1, 1'b0, mk(1'b1, 10'h020, 32'h1234_0002, 4'h3, M_ACK,  1, 32'h0,         1'b0, 2)};
    vecs[3] = '{1'b1, 1'b0, mk(1'b0, 10'h030, 32'h0,         4'hF, M_BOTH, 1, 32'h1234_5678, 1'b1, 2)};
    vecs[4] = '{1'b0, 1'b1, mk(1'b0, 10'h040, 32'h0,         4'hC, M_ERR,  0, 32'h5555_AAAA, 1'b1, 1)};
    vecs[5] = '{1'b1, 1'b0, mk(1'b0, 10'h050, 32'h0,         4'hF, M_SIL,  0, 32'h0BAD_0BAD, 1'b1, 16)};
    vecs[6] = '{1'b1, 1'b0, mk(1'b0, 10'h060, 32'h0,         4'hF, M_ACK,  3, 32'hCAFE_F00D, 1'b0, 4)};
    vecs[7] = '{1'b1, 1'b1, mk(1'b1, 10'h070, 32'h7777_0007, 4'h1, M_ACK,  0, 32'h0,         1'b0, 1)};
    vecs[8] = '{1'b1, 1'b1, mk(1'b0, 10'h080, 32'h0,         4'hF, M_ACK,  1, 32'h8888_0008, 1'b0, 2)};

    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
    bus.m0_we_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m0_adr_i = '0; bus.m1_adr_i = '0;
    bus.m0_dat_i = 32'd0; bus.m1_dat_i = 32'd0;
    bus.m0_sel_i = 4'd0; bus.m1_sel_i = 4'd0;
    bus.wb_dat_i = 32'd0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    tick = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    step();
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    chk("rst_wdat", bus.wb_dat_o, 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("rst_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_done", 32'({bus.m1_done_o, bus.m0_done_o, bus.m1_err_o, bus.m0_err_o}), 32'd0);
    repeat (2) step();

    // Directed vectors: both-requester entries give m1 a distinct address
    for (int v = 0; v < 9; v++) begin
      q1 = vecs[v].q;
      if (vecs[v].r0 && vecs[v].r1) q1.adr = vecs[v].q.adr ^ 10'h3FF;
      run_round(vecs[v].r0, vecs[v].r1, vecs[v].q, q1, 1'b0);
    end

    // Withdrawal in the second BUS cycle still completes, with no second grant
    run_round(1'b1, 1'b0, mk(1'b0, 10'h0AA, 32'h0, 4'hF, M_ACK, 3, 32'h0A0A_0A0A, 1'b0, 4),
              vecs[0].q, 1'b1);

    // Reset mid-transfer after m0 was last served: bus drops at once, no done, m0 priority restored
    run_round(1'b1, 1'b0, vecs[2].q, vecs[2].q, 1'b0);
    q = mk(1'b1, 10'h3C3, 32'hFEED_0001, 4'hF, M_SIL, 0, 32'h0, 1'b1, TO);
    cfg[0] = q;
    exp_own.push_back(0);
    pending[0] = 1'b1;
    raise_tick = tick;
    set_req(0, 1'b1, q);
    repeat (4) step();
    chk("pre_rst_cyc", 32'(bus.wb_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_mid_grant", 32'(bus.grant_o), 32'd0);
    set_req(0, 1'b0, q);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    reset_model();
    repeat (3) step();
    run_round(1'b1, 1'b1, vecs[7].q, vecs[8].q, 1'b0);

    // Contention: six back-to-back rounds with both requesting must alternate
    for (int i = 0; i < 6; i++) begin
      q  = rnd_req();
      q1 = rnd_req();
      run_round(1'b1, 1'b1, q, q1, 1'b0);
    end

    // Randomized rounds against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      q  = rnd_req();
      q1 = rnd_req();
      run_round(r0, r1, q, q1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
